// File: rtl/nioshello_pio_out.sv
// rtl/nioshello_pio_out.sv - Avalon-MM output PIO with set/clear aliases and one-shot pulse engine
module nioshello_pio_out #(
  parameter int          DATA_WIDTH  = 8,
  parameter int          CNT_WIDTH   = 16,
  parameter logic [31:0] RESET_VALUE = 32'h0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic                  irq,
  output logic [DATA_WIDTH-1:0] out_port
);

  localparam logic [2:0] A_DATA      = 3'd0;
  localparam logic [2:0] A_IRQ_MASK  = 3'd1;
  localparam logic [2:0] A_PULSE_LEN = 3'd2;
  localparam logic [2:0] A_PULSE     = 3'd3;
  localparam logic [2:0] A_OUTSET    = 3'd4;
  localparam logic [2:0] A_OUTCLEAR  = 3'd5;
  localparam logic [2:0] A_STATUS    = 3'd6;

  typedef enum logic {S_IDLE = 1'b0, S_PULSE = 1'b1} state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] r_pulse_mask;
  logic                  r_irq_mask;
  logic [CNT_WIDTH-1:0]  r_pulse_len;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_done;

  logic                  w_wr;
  logic [DATA_WIDTH-1:0] w_wd;
  logic                  w_trig;
  logic [31:0]           w_rd_mux;
  logic                  w_unused;

  assign w_wr     = chipselect & ~write_n;
  assign w_wd     = writedata[DATA_WIDTH-1:0];
  assign w_trig   = w_wr && (address == A_PULSE) && (w_wd != '0) && (r_pulse_len != '0);
  assign w_unused = &{1'b0, writedata};

  assign out_port = r_data | r_pulse_mask;
  assign irq      = r_done & r_irq_mask;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data      <= RESET_VALUE[DATA_WIDTH-1:0];
      r_irq_mask  <= 1'b0;
      r_pulse_len <= '0;
    end else if (w_wr) begin
      case (address)
        A_DATA:      r_data      <= w_wd;
        A_IRQ_MASK:  r_irq_mask  <= writedata[0];
        A_PULSE_LEN: r_pulse_len <= writedata[CNT_WIDTH-1:0];
        A_OUTSET:    r_data      <= r_data | w_wd;
        A_OUTCLEAR:  r_data      <= r_data & ~w_wd;
        default:     ;
      endcase
    end
  end

  // Retrigger beats completion; a completion beats a same-cycle STATUS clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_pulse_mask <= '0;
      r_cnt        <= '0;
      r_done       <= 1'b0;
    end else begin
      if (w_wr && (address == A_STATUS)) r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_trig) begin
            r_pulse_mask <= w_wd;
            r_cnt        <= r_pulse_len;
            r_state      <= S_PULSE;
          end
        end
        S_PULSE: begin
          if (w_trig) begin
            r_pulse_mask <= r_pulse_mask | w_wd;
            r_cnt        <= r_pulse_len;
          end else if (r_cnt == CNT_WIDTH'(1)) begin
            r_pulse_mask <= '0;
            r_cnt        <= '0;
            r_done       <= 1'b1;
            r_state      <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_WIDTH'(1);
          end
        end
      endcase
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (address)
      A_DATA:      w_rd_mux = 32'(r_data);
      A_IRQ_MASK:  w_rd_mux = {31'h0, r_irq_mask};
      A_PULSE_LEN: w_rd_mux = 32'(r_pulse_len);
      A_PULSE:     w_rd_mux = 32'(r_pulse_mask);
      A_STATUS:    w_rd_mux = {30'h0, (r_state == S_PULSE), r_done};
      default:     w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= w_rd_mux;
  end

endmodule

// File: doc/nioshello_pio_out.md
# niosHello_pio_out

Avalon-MM slave output PIO: the output-side counterpart of the system's edge-capturing input PIO. It drives a parameterised `out_port`, for example LEDs or strobes to external logic. The port is written directly, or through set/clear aliases. A hardware one-shot pulse engine drives selected bits high for a programmed number of clocks, then raises a maskable completion interrupt. It sits on the Nios II data master's interconnect beside the input PIO.

## Interface
Parameters:
- `DATA_WIDTH`, 8: width of `out_port` and of the data/pulse registers (1..32).
- `CNT_WIDTH`, 16: width of the pulse-length register and counter (1..32).
- `RESET_VALUE`, 0: value of the data register after reset.

Ports:
- `clk`  in  1  single system clock; all logic is on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  3  word address of the register.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe, qualified by `chipselect`.
- `writedata`  in  32  write data; only the low bits used by each register are taken.
- `readdata`  out  32  registered read data, zero-extended.
- `irq`  out  1  pulse-done interrupt, level.
- `out_port`  out  `DATA_WIDTH`  output pins.

## Operation
Register map (word addresses):
- 0 DATA: read/write. Reads return `data_reg`.
- 1 IRQ_MASK: read/write, bit 0 only.
- 2 PULSE_LEN: read/write, `CNT_WIDTH` bits.
- 3 PULSE:
  - A write starts or extends a pulse on the bits set in `writedata`.
  - A read returns `pulse_mask`, the bits currently pulsing.
- 4 OUTSET: write-only. `data_reg <= data_reg | wd`.
- 5 OUTCLEAR: write-only. `data_reg <= data_reg & ~wd`.
- 6 STATUS:
  - Bit 0 is `done`, a sticky flag. Any write clears it.
  - Bit 1 is `busy` (state == PULSE), read-only.
- 7: reserved. Reads return 0 and writes are ignored.
- Write-only addresses read back 0. Reads have no side effects.

Outputs:
- `out_port = data_reg | pulse_mask`, combinational from registers.
- `irq = done & irq_mask[0]`.

Pulse FSM with states IDLE and PULSE and a `CNT_WIDTH` down-counter `cnt`:
- IDLE:
  - Condition: a write to PULSE with `wd[DATA_WIDTH-1:0] != 0` and `PULSE_LEN != 0`.
  - Actions: `pulse_mask <= wd`, `cnt <= PULSE_LEN`, go to PULSE.
  - Otherwise the trigger is ignored. No state change and no `done`.
- PULSE:
  - Each cycle `cnt` decrements.
  - When `cnt == 1`: `pulse_mask <= 0`, `done <= 1`, go to IDLE.
- Retrigger: a valid PULSE write while in PULSE does the following. It has priority over the `cnt == 1` completion.
  - `pulse_mask <= pulse_mask | wd`.
  - `cnt <= PULSE_LEN`.
  - The FSM stays in PULSE and `done` is not set.
- Writing PULSE_LEN during a pulse does not affect the running count; the new value is used at the next trigger.
- A STATUS write on the same cycle that `done` is set leaves `done = 1`: the set wins.
- DATA, OUTSET and OUTCLEAR writes are independent of the pulse engine. A pulsed bit reads high on `out_port` regardless of `data_reg`.

Reset values:
- `data_reg = RESET_VALUE`, so `out_port = RESET_VALUE`.
- `irq_mask`, `PULSE_LEN`, `pulse_mask`, `cnt`, `done` all 0.
- State IDLE.
- `readdata = 0`, `irq = 0`.
- Reset asserted mid-pulse aborts the pulse immediately, asynchronously.

## Timing
- Writes take effect at the rising edge where `chipselect & ~write_n` is sampled. `out_port` and `irq` reflect the change after that edge, so write-to-pin latency is 0 wait cycles.
- `readdata` is registered every cycle from the address mux. Read data is valid one cycle after `address` is presented, giving 1 read-latency cycle.
- Pulse timing for a trigger sampled at edge T with length L:
  - `out_port` bits go high after edge T.
  - They go low after edge T+L, so the pulse is exactly L clock cycles wide.
  - `done`, and `irq` if enabled, rise after edge T+L.
- Retrigger at edge R: bits stay high until edge R+L, measured from the latest trigger.
- Maximum pulse width is 2^`CNT_WIDTH` − 1 cycles.

## Test plan
- Reset: assert `reset_n = 0` with `RESET_VALUE = 8'hA5`, release, then read each address → `out_port = 8'hA5`, `irq = 0`, every read returns 0 except DATA = 0x000000A5.
- Write DATA = 0x0F, OUTSET 0x30, OUTCLEAR 0x05 → `out_port = 0x3A` after each respective edge; DATA reads 0x3A one cycle after the read address.
- Set PULSE_LEN = 5 and IRQ_MASK = 1, then write PULSE = 0x80 at T with DATA = 0 → `out_port[7]` is high for exactly 5 cycles, and STATUS reads 0x2 during the pulse. After T+5, `irq = 1` and STATUS = 0x1; a STATUS write drops `irq` the next cycle.
- Set PULSE_LEN = 4 and write PULSE = 0x01 at T, then PULSE = 0x02 at T+2 → PULSE reads 0x03 while both are active. Both bits fall at T+6, and `done` is set once, at T+6.
- Write PULSE with PULSE_LEN = 0, or write PULSE = 0 → no pin change, `done` stays 0, state stays IDLE.
- Set PULSE_LEN = 1 and trigger, with a STATUS write on the completion edge → 1-cycle pulse, and `done = 1` afterwards. Assert reset mid-pulse in a separate run → `out_port` returns to `RESET_VALUE` immediately.
